mpr_port_arbiter: RTL and testbench

//  Shares the two ports (A, B) of the dual-port register memory MPR among NREQ requesters.
//  - Per cycle: picks up to two requests round-robin and drives them onto MPR port A then port B.
//  - Serialises same-address conflicts.
//  - Returns read data to the owning requester.
//  - Sits between client blocks and the MPR instance; the only master of MPR's ports.

---
 rtl/mpr_port_arbiter_pkg.sv | 19 +
 rtl/mpr_port_arbiter_rr_pick.sv | 32 +++
 rtl/mpr_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mpr_port_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mpr_port_arbiter_pkg.sv
// Shared defaults, read-return tag layout and pointer helper for the MPR port arbiter.
package mpr_port_arbiter_pkg;

    localparam int BITS_DEF = 32;
    localparam int AW_DEF   = 3;
    localparam int NREQ_DEF = 4;
    localparam int OWNER_W  = 3;  // wide enough for NREQ up to 8

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
        logic               is_read;
    } tag_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/mpr_port_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of (req & mask) at or after start, circular.
module mpr_port_arbiter_rr_pick #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [PW-1:0] start_i,
    output logic [N-1:0]  onehot_o,
    output logic          found_o,
    output logic [PW-1:0] idx_o
);

    logic [PW-1:0] j;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        onehot_o = '0;
        found_o  = 1'b0;
        idx_o    = '0;
        j        = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(start_i) + k) % N);
            if (!found_o && req_i[j] && mask_i[j]) begin
                found_o     = 1'b1;
                onehot_o[j] = 1'b1;
                idx_o       = j;
            end
        end
    end

endmodule

// File: rtl/mpr_port_arbiter.sv
// Round-robin arbiter sharing both ports of the dual-port MPR among NREQ requesters,
// with same-address hazard serialisation and per-port read-return tagging.
module mpr_port_arbiter
    import mpr_port_arbiter_pkg::*;
#(
    parameter int BITS = BITS_DEF,
    parameter int AW   = AW_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      req_we_i,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    input  logic [NREQ*BITS-1:0] req_wdata_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      rvalid_o,
    output logic [NREQ*BITS-1:0] rdata_o,
    output logic                 we_a_o,
    output logic                 we_b_o,
    output logic [AW-1:0]        addr_a_o,
    output logic [AW-1:0]        addr_b_o,
    output logic [BITS-1:0]      d_in_a_o,
    output logic [BITS-1:0]      d_in_b_o,
    input  logic [BITS-1:0]      q_out_a_i,
    input  logic [BITS-1:0]      q_out_b_i
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]      first_oh, second_oh;
    logic                 first_found, second_found, second_ok;
    logic [PW-1:0]        first_idx, second_idx;
    logic [AW-1:0]        first_addr, second_addr;
    logic                 first_we, second_we;
    logic [BITS-1:0]      first_wdata, second_wdata;
    logic                 we_a_q, we_b_q;
    logic [AW-1:0]        addr_a_q, addr_b_q;
    logic [BITS-1:0]      d_in_a_q, d_in_b_q;
    tag_t                 tag_a1_q, tag_a2_q, tag_b1_q, tag_b2_q;
    logic [NREQ*BITS-1:0] rdata_q;
    logic [PW-1:0]        own_a, own_b;

    mpr_port_arbiter_rr_pick #(.N(NREQ)) u_pick_first (
        .req_i    (req_i),
        .mask_i   ({NREQ{1'b1}}),
        .start_i  (rr_ptr_q),
        .onehot_o (first_oh),
        .found_o  (first_found),
        .idx_o    (first_idx)
    );

    mpr_port_arbiter_rr_pick #(.N(NREQ)) u_pick_second (
        .req_i    (req_i),
        .mask_i   (~first_oh),
        .start_i  (rr_ptr_q),
        .onehot_o (second_oh),
        .found_o  (second_found),
        .idx_o    (second_idx)
    );

    assign first_addr   = req_addr_i[first_idx*AW +: AW];
    assign second_addr  = req_addr_i[second_idx*AW +: AW];
    assign first_we     = req_we_i[first_idx];
    assign second_we    = req_we_i[second_idx];
    assign first_wdata  = req_wdata_i[first_idx*BITS +: BITS];
    assign second_wdata = req_wdata_i[second_idx*BITS +: BITS];

    // Same address with a write on either side must not share a cycle; the second retries.
    assign second_ok = second_found && !((first_addr == second_addr) && (first_we || second_we));

    assign gnt_o = rst ? '0 : (first_oh | (second_ok ? second_oh : '0));

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (second_ok)
            rr_ptr_d = PW'(wrap_inc(int'(second_idx), NREQ));
        else if (first_found)
            rr_ptr_d = PW'(wrap_inc(int'(first_idx), NREQ));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            d_in_a_q <= '0;
            d_in_b_q <= '0;
            tag_a1_q <= '0;
            tag_a2_q <= '0;
            tag_b1_q <= '0;
            tag_b2_q <= '0;
            rdata_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_a_q   <= first_found & first_we;
            we_b_q   <= second_ok & second_we;
            if (first_found) begin
                addr_a_q <= first_addr;
                if (first_we) d_in_a_q <= first_wdata;
            end
            if (second_ok) begin
                addr_b_q <= second_addr;
                if (second_we) d_in_b_q <= second_wdata;
            end
            tag_a1_q <= '{valid: first_found, owner: OWNER_W'(first_idx), is_read: ~first_we};
            tag_b1_q <= '{valid: second_ok, owner: OWNER_W'(second_idx), is_read: ~second_we};
            tag_a2_q <= tag_a1_q;
            tag_b2_q <= tag_b1_q;
            rdata_q  <= rdata_o;
        end
    end

    assign own_a = tag_a2_q.owner[PW-1:0];
    assign own_b = tag_b2_q.owner[PW-1:0];

    // Returning owners see q_out directly; everyone else holds their last data.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = rdata_q;
        if (tag_a2_q.valid && tag_a2_q.is_read) begin
            rvalid_o[own_a]               = 1'b1;
            rdata_o[own_a*BITS +: BITS]   = q_out_a_i;
        end
        if (tag_b2_q.valid && tag_b2_q.is_read) begin
            rvalid_o[own_b]               = 1'b1;
            rdata_o[own_b*BITS +: BITS]   = q_out_b_i;
        end
    end

    assign we_a_o   = we_a_q;
    assign we_b_o   = we_b_q;
    assign addr_a_o = addr_a_q;
    assign addr_b_o = addr_b_q;
    assign d_in_a_o = d_in_a_q;
    assign d_in_b_o = d_in_b_q;

endmodule

// File: tb/tb_mpr_port_arbiter.sv
// Directed bench: arbiter plus a behavioural dual-port MPR, scoreboarded read returns.
module tb_mpr_port_arbiter;

    localparam int BITS = 32;
    localparam int AW   = 3;
    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req, req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*BITS-1:0] req_wdata;
    logic [NREQ-1:0]      gnt, rvalid;
    logic [NREQ*BITS-1:0] rdata;
    logic                 we_a, we_b;
    logic [AW-1:0]        addr_a, addr_b;
    logic [BITS-1:0]      d_in_a, d_in_b, q_out_a, q_out_b;

    always #10 clk = ~clk;

    mpr_port_arbiter #(.BITS(BITS), .AW(AW), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .we_a_o      (we_a),
        .we_b_o      (we_b),
        .addr_a_o    (addr_a),
        .addr_b_o    (addr_b),
        .d_in_a_o    (d_in_a),
        .d_in_b_o    (d_in_b),
        .q_out_a_i   (q_out_a),
        .q_out_b_i   (q_out_b)
    );

    // Behavioural MPR: synchronous write, registered read (read-before-write).
    logic [BITS-1:0] mem [8];
    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= d_in_a;
        if (we_b) mem[addr_b] <= d_in_b;
        q_out_a <= mem[addr_a];
        q_out_b <= mem[addr_b];
    end

    typedef struct {
        int              due;
        int              owner;
        logic [BITS-1:0] data;
    } exp_t;

    exp_t            sb[$];
    logic [BITS-1:0] shadow [8];
    int              checks = 0;
    int              errors = 0;
    int              cyc    = 0;
    int              gcount [NREQ];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pops every read due this cycle and checks no unexpected rvalid is raised.
    always @(negedge clk) begin
        int   n;
        exp_t e;
        n = 0;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            n++;
            chk("rvalid_bit", 128'(rvalid[e.owner]), 128'(1));
            chk("rdata", 128'(rdata[e.owner*BITS +: BITS]), 128'(e.data));
        end
        chk("rvalid_count", 128'($countones(rvalid)), 128'(n));
    end

    // One arbitration cycle: drive at +1 after the edge, check gnt mid-cycle, release after.
    task automatic step(input logic [3:0] r, input logic [3:0] w, input logic [11:0] a,
                        input logic [127:0] d, input logic [3:0] eg, input string tag);
        logic [2:0] ad;
        req    = r;
        req_we = w;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]       = r[i] ? a[i*AW +: AW] : 'x;
            req_wdata[i*BITS +: BITS]  = r[i] ? d[i*BITS +: BITS] : 'x;
        end
        #5;
        chk(tag, 128'(gnt), 128'(eg));
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gcount[i]++;
            if (eg[i]) begin
                ad = a[i*AW +: AW];
                if (w[i]) shadow[ad] = d[i*BITS +: BITS];
                else      sb.push_back('{due: cyc + 2, owner: i, data: shadow[ad]});
            end
        end
        @(posedge clk);
        #1;
        req       = '0;
        req_we    = '0;
        req_addr  = 'x;
        req_wdata = 'x;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        req       = '0;
        req_we    = '0;
        req_addr  = 'x;
        req_wdata = 'x;
        #2 rst = 1'b1;
        #3;
        chk("init_we_a", 128'(we_a), 128'(0));
        chk("init_addr_a", 128'(addr_a), 128'(0));
        chk("init_rdata", 128'(rdata), 128'(0));
        idle(2);
        rst = 1'b0;
        idle(1);

        // Reset mid-stream with two reads in flight.
        step(4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd4}, {96'd0, 32'd55}, 4'b0001, "rst_pre_wr");
        step(4'b0011, 4'b0000, {3'd0, 3'd0, 3'd2, 3'd1}, '0, 4'b0011, "rst_pre_rd");
        rst = 1'b1;
        sb.delete();
        req    = 4'b0001;
        req_we = 4'b0000;
        req_addr = '0;
        #1;
        chk("rst_gnt", 128'(gnt), 128'(0));
        chk("rst_we", 128'({we_a, we_b}), 128'(0));
        chk("rst_addr", 128'({addr_a, addr_b}), 128'(0));
        chk("rst_d_in", 128'({d_in_a, d_in_b}), 128'(0));
        chk("rst_rvalid", 128'(rvalid), 128'(0));
        chk("rst_rdata", rdata, 128'(0));
        req = '0;
        idle(2);
        rst = 1'b0;
        idle(4);

        // Write then immediate read by r0.
        step(4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, {96'd0, 32'd12}, 4'b0001, "t2_wr");
        chk("t2_we_a", 128'({we_a, we_b}), 128'(2'b10));
        chk("t2_addr_a", 128'(addr_a), 128'(3));
        chk("t2_d_in_a", 128'(d_in_a), 128'(12));
        step(4'b0001, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd3}, '0, 4'b0001, "t2_rd");
        chk("t2_rd_we", 128'({we_a, we_b}), 128'(0));

        // Two distinct writes in one cycle, then read both back.
        step(4'b0110, 4'b0110, {3'd0, 3'd6, 3'd5, 3'd0}, {32'd0, 32'd7, 32'd99, 32'd0},
             4'b0110, "t3_wr");
        chk("t3_we", 128'({we_a, we_b}), 128'(2'b11));
        chk("t3_addr", 128'({addr_a, addr_b}), 128'({3'd5, 3'd6}));
        chk("t3_d_in", 128'({d_in_a, d_in_b}), 128'({32'd99, 32'd7}));
        step(4'b0110, 4'b0000, {3'd0, 3'd6, 3'd5, 3'd0}, '0, 4'b0110, "t3_rd");

        // Bring rr_ptr to 0, then a write/read conflict on [5].
        step(4'b1000, 4'b0000, {3'd5, 3'd0, 3'd0, 3'd0}, '0, 4'b1000, "t4_align");
        step(4'b0011, 4'b0001, {3'd0, 3'd0, 3'd5, 3'd5}, {96'd0, 32'd10}, 4'b0001, "t4_conflict");
        chk("t4_we", 128'({we_a, we_b}), 128'(2'b10));
        step(4'b0010, 4'b0000, {3'd0, 3'd0, 3'd5, 3'd0}, '0, 4'b0010, "t4_retry");

        // Same-address reads granted together.
        step(4'b1000, 4'b1000, {3'd7, 3'd0, 3'd0, 3'd0}, {32'd8, 96'd0}, 4'b1000, "t6_wr");
        step(4'b1100, 4'b0000, {3'd7, 3'd7, 3'd0, 3'd0}, '0, 4'b1100, "t6_rd");
        idle(3);

        // Fairness: all four hold reads for 8 cycles.
        for (int i = 0; i < NREQ; i++) gcount[i] = 0;
        for (int k = 0; k < 8; k++)
            step(4'b1111, 4'b0000, {3'd7, 3'd6, 3'd5, 3'd3}, '0,
                 (k % 2 == 0) ? 4'b0011 : 4'b1100, "t5_fair");
        for (int i = 0; i < NREQ; i++) chk("t5_count", 128'(gcount[i]), 128'(4));

        idle(4);
        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
